// File: rtl/pyramid_pkg.sv
// Shared types and helpers for the pyramid level scheduler.
package pyramid_pkg;
    localparam int Max_Level      = 4;
    localparam int Level_Bit_Size = 3;

    typedef enum logic [2:0] {IDLE, LOAD, SCAN, FLUSH, DONE} state_t;

    function automatic int level_width(input int img_w, input int lvl);
        return img_w >> lvl;
    endfunction

    function automatic int level_height(input int img_h, input int lvl);
        return img_h >> lvl;
    endfunction
endpackage

// File: rtl/pyramid_level_scheduler_if.sv
// Pixel coordinate stream from the scheduler to the flow datapath / BRAM address port.
interface pyramid_level_scheduler_if #(
    parameter int Coord_Bit_Size   = 7,
    parameter int Address_Bit_Size = 12,
    parameter int Level_Bit_Size   = 3
);
    logic                        pix_valid;
    logic                        pix_ready;
    logic [Coord_Bit_Size-1:0]   x;
    logic [Coord_Bit_Size-1:0]   y;
    logic [Address_Bit_Size-1:0] addr;
    logic [Level_Bit_Size-1:0]   level;
    logic                        level_start;
    logic                        last_pix;

    modport master (output pix_valid, x, y, addr, level, level_start, last_pix,
                    input  pix_ready);
    modport slave  (input  pix_valid, x, y, addr, level, level_start, last_pix,
                    output pix_ready);
endinterface

// File: rtl/raster_addr_counter.sv
// Raster x/y walker with a running linear address; holds when not advancing.
module raster_addr_counter #(
    parameter int CW = 7,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          advance,
    input  logic [CW-1:0] w_l,
    input  logic [CW-1:0] h_l,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic [AW-1:0] addr,
    output logic          last
);
    logic x_end, y_end;

    assign x_end = (x == w_l - CW'(1));
    assign y_end = (y == h_l - CW'(1));
    assign last  = x_end && y_end;

    // addr replaces a y*W_L+x multiply: it simply tracks raster order
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (clear) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (advance) begin
            if (x_end) begin
                x <= '0;
                y <= y_end ? '0 : y + CW'(1);
            end else begin
                x <= x + CW'(1);
            end
            addr <= last ? '0 : addr + AW'(1);
        end
    end
endmodule

// File: rtl/pyramid_level_scheduler.sv
// Coarse-to-fine pyramid sequencer: per level, raster coordinates under valid/ready, then drain.
// Optional PYRAMID_STALL_CNT_EN adds a per-level back-pressure counter (stall_cnt, stall_cnt_valid).
module pyramid_level_scheduler
    import pyramid_pkg::*;
#(
    parameter int Image_Width      = 64,
    parameter int Image_Height     = 48,
    parameter int Coord_Bit_Size   = $clog2(Image_Width) + 1,
    parameter int Address_Bit_Size = $clog2(Image_Width * Image_Height)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [Level_Bit_Size-1:0] total_level,
    input  logic                      core_idle,
    output logic                      busy,
    output logic                      done,
`ifdef PYRAMID_STALL_CNT_EN
    output logic [15:0]               stall_cnt,
    output logic                      stall_cnt_valid,
`endif
    pyramid_level_scheduler_if.master pix
);
    state_t                    state, state_nxt;
    logic [Level_Bit_Size-1:0] lvl;
    logic [Level_Bit_Size-1:0] n_clamp;
    logic                      n_zero;
    logic [Coord_Bit_Size-1:0] w_l, h_l;
    logic                      cnt_last;

    assign n_clamp = (total_level > Level_Bit_Size'(Max_Level)) ? Level_Bit_Size'(Max_Level)
                                                                : total_level;
    assign w_l = Coord_Bit_Size'(level_width(Image_Width, int'(lvl)));
    assign h_l = Coord_Bit_Size'(level_height(Image_Height, int'(lvl)));

    // lvl is updated on entry to LOAD so level is already correct during the level_start cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            lvl    <= '0;
            n_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                n_zero <= (n_clamp == '0);
                lvl    <= (n_clamp == '0) ? '0 : n_clamp - Level_Bit_Size'(1);
            end else if (state == FLUSH && core_idle && lvl != '0) begin
                lvl <= lvl - Level_Bit_Size'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = n_zero ? DONE : SCAN;
            SCAN:    if (pix.pix_ready && cnt_last) state_nxt = FLUSH;
            FLUSH:   if (core_idle) state_nxt = (lvl == '0) ? DONE : LOAD;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    raster_addr_counter #(.CW(Coord_Bit_Size), .AW(Address_Bit_Size)) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == LOAD),
        .advance (state == SCAN && pix.pix_ready),
        .w_l     (w_l),
        .h_l     (h_l),
        .x       (pix.x),
        .y       (pix.y),
        .addr    (pix.addr),
        .last    (cnt_last)
    );

    assign pix.pix_valid   = (state == SCAN);
    assign pix.last_pix    = (state == SCAN) && cnt_last;
    assign pix.level_start = (state == LOAD) && !n_zero;
    assign pix.level       = lvl;
    assign busy            = (state == LOAD) || (state == SCAN) || (state == FLUSH);
    assign done            = (state == DONE);

`ifdef PYRAMID_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_q <= '0;
        else if (state == LOAD)
            stall_q <= '0;
        else if (state == SCAN && !pix.pix_ready && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
    end

    assign stall_cnt       = stall_q;
    assign stall_cnt_valid = (state == FLUSH) && core_idle;
`endif
endmodule

// File: tb/tb_pyramid_level_scheduler.sv
// Directed + randomized bench for pyramid_level_scheduler (64x48 image) against a raster model.
module tb_pyramid_level_scheduler;
    localparam int IW = 64;
    localparam int IH = 48;
    localparam int CB = 7;
    localparam int AB = 12;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] total_level;
    logic       core_idle;
    logic       busy, done;
`ifdef PYRAMID_STALL_CNT_EN
    logic [15:0] stall_cnt;
    logic        stall_cnt_valid;
`endif

    int checks = 0;
    int errors = 0;

    pyramid_level_scheduler_if #(.Coord_Bit_Size(CB), .Address_Bit_Size(AB), .Level_Bit_Size(3)) pif ();

    pyramid_level_scheduler #(.Image_Width(IW), .Image_Height(IH)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .total_level (total_level),
        .core_idle   (core_idle),
        .busy        (busy),
        .done        (done),
`ifdef PYRAMID_STALL_CNT_EN
        .stall_cnt       (stall_cnt),
        .stall_cnt_valid (stall_cnt_valid),
`endif
        .pix         (pif.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // pct: percent of cycles with pix_ready high; negative means alternate 1,0,1,0...
    task automatic run_frame(input int tl, input int pct, input int idle_lo);
        int n, w, h, idx, cyc, stalls, ex, ey;
        logic [29:0] exp_v;
        n = (tl > 4) ? 4 : tl;
        @(negedge clk);
        start       = 1'b1;
        total_level = tl[2:0];
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("busy_after_start", busy, 1);
        chk("level_start_first", pif.level_start, (n > 0));
        if (n == 0) begin
            chk("no_valid_load", pif.pix_valid, 0);
            @(negedge clk); #1;
            chk("done_zero_lvl", done, 1);
            chk("busy_in_done", busy, 0);
            chk("no_valid_done", pif.pix_valid, 0);
            @(negedge clk); #1;
            chk("done_one_cycle", done, 0);
            return;
        end
        chk("level_first", pif.level, n - 1);
        for (int L = n - 1; L >= 0; L--) begin
            w = IW >> L;
            h = IH >> L;
            idx = 0; cyc = 0; stalls = 0;
            while (idx < w * h && cyc < w * h * 20 + 100) begin
                @(negedge clk);
                if (pct >= 100)   pif.pix_ready = 1'b1;
                else if (pct < 0) pif.pix_ready = (cyc % 2 == 0);
                else              pif.pix_ready = ($urandom_range(99) < pct);
                start     = ($urandom_range(15) == 0);
                core_idle = $urandom_range(1);
                #1;
                cyc++;
                ex = idx % w;
                ey = idx / w;
                exp_v = {CB'(ex), CB'(ey), AB'(ey * w + ex), 3'(L), (idx == w * h - 1)};
                chk("scan_valid", pif.pix_valid, 1);
                chk("scan_coord", {pif.x, pif.y, pif.addr, pif.level, pif.last_pix}, exp_v);
                if (pif.pix_ready) idx++;
                else stalls++;
            end
            chk("scan_complete", idx, w * h);
            for (int k = 1; k <= idle_lo + 1; k++) begin
                @(negedge clk);
                start     = 1'b0;
                core_idle = (k == idle_lo + 1);
                #1;
                chk("flush_no_valid", pif.pix_valid, 0);
                chk("flush_busy", busy, 1);
`ifdef PYRAMID_STALL_CNT_EN
                chk("stall_valid", stall_cnt_valid, (k == idle_lo + 1));
                if (k == idle_lo + 1) chk("stall_cnt", stall_cnt, stalls);
`endif
            end
            @(negedge clk); #1;
            if (L > 0) begin
                chk("level_start_next", pif.level_start, 1);
                chk("level_next", pif.level, L - 1);
                chk("load_no_valid", pif.pix_valid, 0);
            end else begin
                chk("done_pulse", done, 1);
                chk("busy_in_done", busy, 0);
                start = 1'b1;
            end
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("done_one_cycle", done, 0);
        chk("start_in_done_ignored", {busy, pif.level_start}, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; total_level = '0; core_idle = 1'b1; pif.pix_ready = 1'b0;
        #1;
        chk("reset_state", {pif.pix_valid, pif.x, pif.y, pif.addr, pif.level,
                            pif.level_start, pif.last_pix, busy, done}, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        run_frame(2, 100, 0);
        run_frame(0, 100, 0);
        run_frame(1, -1, 5);
        run_frame(7, 70, 2);

        // reset in the middle of scanning level 1
        @(negedge clk);
        start = 1'b1; total_level = 3'd2;
        @(negedge clk);
        start = 1'b0; pif.pix_ready = 1'b1;
        repeat (12) @(negedge clk);
        #1;
        chk("pre_reset_level", pif.level, 1);
        reset = 1'b1;
        #1;
        chk("reset_async", {pif.pix_valid, pif.x, pif.y, pif.addr, pif.level,
                            pif.level_start, pif.last_pix, busy, done}, 0);
        @(negedge clk);
        reset = 1'b0;

        run_frame(3, 80, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
